if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline inside top_level.
- Owns the PC and drives the instruction-memory address; the combinational instruction memory returns the word.
- Captures instruction and PC+4 into the IF/ID register that feeds decode.
- Handles decode-stage stalls, EX-stage redirects (branch/jump/jr), and halts fetch after a trap is fetched.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word placed in IF/ID on flush, halt or reset.
- TRAP_OPCODE, 6'h11, DLX trap opcode, compared against instruction bits [0:5].

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  [0:31]  byte address to instruction memory; equals pc with bits [30:31] forced to 0.
- imem_data  in  [0:31]  instruction word at imem_addr, valid in the same cycle.
- stall_id  in  1  decode hazard; hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from EX; flush and reload PC.
- redirect_target  in  [0:31]  new PC; low 2 bits ignored.
- if_id_instr  out  [0:31]  registered instruction to decode.
- if_id_pc4  out  [0:31]  registered PC+4 of that instruction, used for link and branch offsets.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_halted  out  1  high in HALT state.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC, state=RUN.
  - if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_halted=0.
- State machine, two states, RUN and HALT. Conditions are evaluated in priority order each rising edge:
  1. redirect_valid=1 (overrides stall_id):
     - pc<=redirect_target&~3.
     - IF/ID<={NOP_INSTR,0,valid 0}.
     - state<=RUN; this clears HALT, because a trap in the branch shadow is squashed.
  2. stall_id=1: pc, IF/ID and state hold.
  3. RUN, no stall:
     - IF/ID<={imem_data, pc+4, valid 1}.
     - If imem_data[0:5]==TRAP_OPCODE: pc holds, state<=HALT.
     - Otherwise pc<=pc+4.
  4. HALT, no stall: IF/ID<={NOP_INSTR, if_id_pc4 unchanged, valid 0}; pc holds.
- fetch_halted is combinational from state (1 in HALT).
- Latency: the word at address A is presented to decode on the edge after the cycle in which pc==A and neither stall_id nor redirect_valid is asserted. Throughput is 1 instruction per cycle.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No misalignment trap; the low bits are always masked.
- The trap word itself is passed down valid so that MEM can raise trap_mem. Subsequent bubbles let the pipeline drain.
- Reset asserted mid-stall or mid-HALT returns to the reset values immediately; fetch restarts at RESET_PC on the first edge after release.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, add three 32-bit output counters, all reset to 0 and saturating at 32'hFFFF_FFFF:
  - perf_fetched: increments on each valid IF/ID load.
  - perf_stall: increments on each cycle with stall_id=1 and redirect_valid=0.
  - perf_flush: increments on each redirect_valid=1 cycle.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode localparams (TRAP_OPCODE, J, JAL, BEQZ, BNEZ);
  - NOP_INSTR and RESET_PC defaults;
  - the fetch state enum {RUN, HALT};
  - the IF/ID payload struct {instr, pc4, valid}.
- One sub-module, if_id_reg: a holdable/flushable pipeline register carrying that payload, reused for the same stall/flush semantics later.

Test Plan:
- Reset release, imem at 0x0/0x4/0x8 = 0x20010005/0x20020003/0x00221820, no stall:
  - imem_addr sequences 0x0, 0x4, 0x8.
  - if_id_instr follows one cycle later with if_id_pc4 = 0x4, 0x8, 0xC and valid=1.
- stall_id high for 2 cycles while pc=0x8: imem_addr stays 0x8 and IF/ID stays {0x20020003, 0x8} for both cycles; fetch resumes with no duplicate or lost word.
- redirect_valid=1, target=0x43, with stall_id=1 in the same cycle:
  - next pc=0x40;
  - IF/ID valid=0 with NOP_INSTR;
  - the following cycle loads imem[0x40] with pc4=0x44.
- Trap word 0x44000300 at 0x10:
  - IF/ID gets it with valid=1;
  - fetch_halted=1 from the next cycle;
  - pc pinned at 0x10 and valid=0 thereafter.
  - A later redirect to 0x20 resumes fetch with fetch_halted=0.
- pc=0xFFFF_FFFC with a non-trap word: if_id_pc4=0x0 and next imem_addr=0x0.
- Reset pulsed low asynchronously mid-HALT: outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: DLX opcodes, fetch defaults, fetch FSM states
// and the IF/ID payload carried between fetch and decode.
package pipeline_pkg;

  localparam logic [0:5] OP_J    = 6'h02;
  localparam logic [0:5] OP_JAL  = 6'h03;
  localparam logic [0:5] OP_BEQZ = 6'h04;
  localparam logic [0:5] OP_BNEZ = 6'h05;
  localparam logic [0:5] OP_TRAP = 6'h11;

  localparam logic [0:31] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [0:31] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic {
    StRun,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [0:31] instr;
    logic [0:31] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, decode/EX control and IF/ID outputs.
// Perf counter signals exist only when IF_PERF_CNT_EN is defined.
interface if_fetch_stage_if;
  logic [0:31] imem_addr;
  logic [0:31] imem_data;
  logic        stall_id;
  logic        redirect_valid;
  logic [0:31] redirect_target;
  logic [0:31] if_id_instr;
  logic [0:31] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall_id,
    input  redirect_valid,
    input  redirect_target,
    output if_id_instr,
    output if_id_pc4,
    output if_id_valid,
`ifdef IF_PERF_CNT_EN
    output perf_fetched,
    output perf_stall,
    output perf_flush,
`endif
    output fetch_halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall_id,
    output redirect_valid,
    output redirect_target,
    input  if_id_instr,
    input  if_id_pc4,
    input  if_id_valid,
`ifdef IF_PERF_CNT_EN
    input  perf_fetched,
    input  perf_stall,
    input  perf_flush,
`endif
    input  fetch_halted
  );
endinterface

// File: rtl/if_id_reg.sv
// Holdable/flushable IF/ID pipeline register; flush beats hold, reset and
// flush both load a bubble.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [0:31] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush_i,
  input  logic   hold_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  localparam if_id_t Bubble = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  if_id_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = Bubble;
    end else if (!hold_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= Bubble;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, handles stalls, EX redirects and
// halting after a trap. Optional perf counters under IF_PERF_CNT_EN.
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [0:31] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [0:31] NOP_INSTR   = NOP_INSTR_DEFAULT,
  parameter logic [0:5]  TRAP_OPCODE = OP_TRAP
) (
  input logic               clk,
  input logic               reset,
  if_fetch_stage_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [0:31]  pc_q, pc_d;
  logic [0:31]  fetch_addr;
  logic [0:31]  pc_plus4;
  logic         is_trap;
  logic         load_valid;
  if_id_t       if_id_d, if_id_q;

  assign fetch_addr = pc_q & ~32'h3;
  assign pc_plus4   = fetch_addr + 32'd4;
  assign is_trap    = (bus.imem_data[0:5] == TRAP_OPCODE);
  assign load_valid = !bus.redirect_valid && !bus.stall_id && (state_q == StRun);

  // Flush/hold priority lives in if_id_reg; this only picks the payload.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_target & ~32'h3;
      state_d = StRun;
    end else if (!bus.stall_id) begin
      unique case (state_q)
        StRun: begin
          if_id_d = '{instr: bus.imem_data, pc4: pc_plus4, valid: 1'b1};
          if (is_trap) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_plus4;
          end
        end
        StHalt: begin
          if_id_d = '{instr: NOP_INSTR, pc4: if_id_q.pc4, valid: 1'b0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC & ~32'h3;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect_valid),
    .hold_i  (bus.stall_id),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  assign bus.imem_addr    = fetch_addr;
  assign bus.if_id_instr  = if_id_q.instr;
  assign bus.if_id_pc4    = if_id_q.pc4;
  assign bus.if_id_valid  = if_id_q.valid;
  assign bus.fetch_halted = (state_q == StHalt);

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Counters saturate rather than wrap.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    perf_flush_d   = perf_flush_q;
    if (load_valid && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (bus.stall_id && !bus.redirect_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (bus.redirect_valid && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
      perf_flush_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
      perf_flush_q   <= perf_flush_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
  assign bus.perf_flush   = perf_flush_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs change and outputs are sampled on
// the falling edge, against a small instruction-memory table.
module tb_if_fetch_stage;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0003;
      32'h0000_0008: return 32'h0022_1820;
      32'h0000_0010: return 32'h4400_0300;
      32'h0000_0020: return 32'h1234_5678;
      32'h0000_0040: return 32'hAAAA_0001;
      32'hFFFF_FFFC: return 32'h2001_FFFF;
      default:       return 32'h0C00_0000 + addr;
    endcase
  endfunction

  assign bus.imem_data = imem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                          input logic valid);
    chk({tag, ".instr"}, bus.if_id_instr, instr);
    chk({tag, ".pc4"}, bus.if_id_pc4, pc4);
    chk({tag, ".valid"}, {31'h0, bus.if_id_valid}, {31'h0, valid});
  endtask

  task automatic chk_halt(input string tag, input logic exp);
    chk(tag, {31'h0, bus.fetch_halted}, {31'h0, exp});
  endtask

  initial begin
    reset               = 1'b0;
    bus.stall_id        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;

    // Reset state
    #3;
    chk("rst.addr", bus.imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk_halt("rst.halt", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Straight-line fetch
    @(negedge clk);
    chk("seq.addr0", bus.imem_addr, 32'h4);
    chk_ifid("seq0", 32'h2001_0005, 32'h4, 1'b1);
    @(negedge clk);
    chk("seq.addr1", bus.imem_addr, 32'h8);
    chk_ifid("seq1", 32'h2002_0003, 32'h8, 1'b1);
    bus.stall_id = 1'b1;

    // Two stall cycles at pc=0x8
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall.addr", bus.imem_addr, 32'h8);
      chk_ifid("stall", 32'h2002_0003, 32'h8, 1'b1);
    end
    bus.stall_id = 1'b0;
    @(negedge clk);
    chk("resume.addr", bus.imem_addr, 32'hC);
    chk_ifid("resume", 32'h0022_1820, 32'hC, 1'b1);

    // Redirect beats a simultaneous stall; target low bits dropped
    bus.stall_id        = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h43;
    @(negedge clk);
    chk("redir.addr", bus.imem_addr, 32'h40);
    chk_ifid("redir", 32'h0, 32'h0, 1'b0);
    bus.stall_id       = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk_ifid("redir.load", 32'hAAAA_0001, 32'h44, 1'b1);
    chk("redir.next", bus.imem_addr, 32'h44);

    // Trap at 0x10
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10;
    @(negedge clk);
    chk("trap.addr", bus.imem_addr, 32'h10);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk_ifid("trap", 32'h4400_0300, 32'h14, 1'b1);
    chk_halt("trap.halt", 1'b1);
    chk("trap.pc", bus.imem_addr, 32'h10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_ifid("halt", 32'h0, 32'h14, 1'b0);
      chk("halt.pc", bus.imem_addr, 32'h10);
      chk_halt("halt.halt", 1'b1);
    end

    // Redirect out of HALT
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h20;
    @(negedge clk);
    chk_halt("unhalt.halt", 1'b0);
    chk("unhalt.addr", bus.imem_addr, 32'h20);
    chk_ifid("unhalt", 32'h0, 32'h0, 1'b0);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk_ifid("unhalt.load", 32'h1234_5678, 32'h24, 1'b1);

    // PC wrap at the top of the address space
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap.addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk_ifid("wrap", 32'h2001_FFFF, 32'h0, 1'b1);
    chk("wrap.next", bus.imem_addr, 32'h0);

    // Asynchronous reset while halted
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk_halt("pre_rst.halt", 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_halt("arst.halt", 1'b0);
    chk("arst.addr", bus.imem_addr, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("arst.hold", bus.imem_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk_ifid("restart", 32'h2001_0005, 32'h4, 1'b1);
    chk("restart.addr", bus.imem_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
